// File: rtl/io_pad_ctrl_pkg.sv
// Shared definitions for the pad configuration controller: config word
// layout, special register addresses, reset word and controller states.
package io_pad_ctrl_pkg;

  // Number of stored bits per pad config word; bits above this are reserved.
  localparam int CFG_W = 9;

  // Config word field positions.
  localparam int F_FUNC_LSB = 0;
  localparam int F_FUNC_MSB = 1;
  localparam int F_CS       = 2;
  localparam int F_SL       = 3;
  localparam int F_PU       = 4;
  localparam int F_PD       = 5;
  localparam int F_IE       = 6;
  localparam int F_GPIO_OE  = 7;
  localparam int F_GPIO_OUT = 8;
  localparam int F_IN_SYNC  = 9;  // readback-only: synchronized pad input

  localparam logic [5:0] ADDR_CTRL   = 6'd62;
  localparam logic [5:0] ADDR_STATUS = 6'd63;

  localparam logic [15:0] CFG_RESET = 16'h0040;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    IDLE   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // A pad must never pull both ways; pull-up wins when both are requested.
  function automatic logic [CFG_W-1:0] cfg_sanitize(input logic [CFG_W-1:0] w);
    logic [CFG_W-1:0] r;
    r = w;
    if (w[F_PU] && w[F_PD]) r[F_PD] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/io_pad_ctrl_sync.sv
// Two-flop synchronizer bank for asynchronous pad inputs.
module io_pad_ctrl_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_pad_ctrl.sv
// Pad configuration controller: shadow/active config register file with
// atomic commit, post-reset safe hold, and GPIO/peripheral pin muxing.
module io_pad_ctrl
  import io_pad_ctrl_pkg::*;
#(
  parameter int NUM_BIDIR     = 54,
  parameter int NUM_FUNC      = 4,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic                              cfg_we,
  input  logic [5:0]                        cfg_addr,
  input  logic [15:0]                       cfg_wdata,
  output logic [15:0]                       cfg_rdata,
  output logic                              cfg_rvalid,
  input  logic [NUM_BIDIR*(NUM_FUNC-1)-1:0] fn_out,
  input  logic [NUM_BIDIR*(NUM_FUNC-1)-1:0] fn_oe,
  output logic [NUM_BIDIR-1:0]              fn_in,
  input  logic [NUM_BIDIR-1:0]              io_in,
  output logic [NUM_BIDIR-1:0]              io_out,
  output logic [NUM_BIDIR-1:0]              io_oe,
  output logic [NUM_BIDIR-1:0]              io_cs,
  output logic [NUM_BIDIR-1:0]              io_sl,
  output logic [NUM_BIDIR-1:0]              io_ie,
  output logic [NUM_BIDIR-1:0]              io_pu,
  output logic [NUM_BIDIR-1:0]              io_pd
);

  localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CFG_W-1:0]  CFG_RST  = CFG_RESET[CFG_W-1:0];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit, busy, settled;
  logic               wr_acc, rd_acc;
  logic [CFG_W-1:0]   shadow_q [NUM_BIDIR];
  logic [CFG_W-1:0]   active_q [NUM_BIDIR];
  logic [NUM_BIDIR-1:0] in_sync;
  logic [15:0]        rd_val, rdata_q;
  logic               rvalid_q;
  logic [CFG_W-1:0]   w;
  logic               unused_wdata;

  assign wr_acc       = cfg_valid & cfg_ready & cfg_we;
  assign rd_acc       = cfg_valid & cfg_ready & ~cfg_we;
  assign settled      = (state_q != HOLD);
  assign fn_in        = io_in;
  assign cfg_rdata    = rdata_q;
  assign cfg_rvalid   = rvalid_q;
  assign unused_wdata = ^cfg_wdata[15:CFG_W];

  io_pad_ctrl_sync #(.W(NUM_BIDIR)) u_sync (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .d_i   (io_in),
    .q_o   (in_sync)
  );

  // Controller state and settle counter registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: settle hold, request acceptance, one-cycle commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    commit    = 1'b0;
    case (state_q)
      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[0]) state_d = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = HOLD;
    endcase
  end

  // Shadow words take register writes; active words load all shadows on commit.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BIDIR; i++) begin
        shadow_q[i] <= CFG_RST;
        active_q[i] <= CFG_RST;
      end
    end else begin
      for (int i = 0; i < NUM_BIDIR; i++) begin
        if (wr_acc && (cfg_addr == 6'(i))) shadow_q[i] <= cfg_sanitize(cfg_wdata[CFG_W-1:0]);
        if (commit) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Read data selection for the addressed register.
  always_comb begin
    rd_val = '0;
    if (cfg_addr == ADDR_STATUS) rd_val = {14'b0, busy, settled};
    for (int i = 0; i < NUM_BIDIR; i++) begin
      if (cfg_addr == 6'(i)) rd_val = {6'b0, in_sync[i], shadow_q[i]};
    end
  end

  // Read response: data held until the next accepted read, valid pulses once.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rd_val;
    end
  end

  // Pad drive: safe input-only during hold, else active word with function mux.
  always_comb begin
    io_out = '0;
    io_oe  = '0;
    io_cs  = '0;
    io_sl  = '0;
    io_pu  = '0;
    io_pd  = '0;
    io_ie  = '1;
    w      = '0;
    if (state_q != HOLD) begin
      for (int i = 0; i < NUM_BIDIR; i++) begin
        w         = active_q[i];
        io_out[i] = w[F_GPIO_OUT];
        io_oe[i]  = w[F_GPIO_OE];
        io_cs[i]  = w[F_CS];
        io_sl[i]  = w[F_SL];
        io_pu[i]  = w[F_PU];
        io_pd[i]  = w[F_PD];
        io_ie[i]  = w[F_IE];
        // Unsupported function codes fall through to GPIO.
        for (int f = 1; f < NUM_FUNC; f++) begin
          if (w[F_FUNC_MSB:F_FUNC_LSB] == 2'(f)) begin
            io_out[i] = fn_out[(f-1)*NUM_BIDIR + i];
            io_oe[i]  = fn_oe[(f-1)*NUM_BIDIR + i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Self-checking bench for io_pad_ctrl with a read-expectation scoreboard.
module tb_io_pad_ctrl;

  localparam int NB = 54;
  localparam int NF = 4;
  localparam int SC = 16;
  localparam int FW = NB * (NF - 1);

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          cfg_we = 1'b0;
  logic [5:0]    cfg_addr = '0;
  logic [15:0]   cfg_wdata = '0;
  logic [15:0]   cfg_rdata;
  logic          cfg_rvalid;
  logic [FW-1:0] fn_out = '0;
  logic [FW-1:0] fn_oe = '0;
  logic [NB-1:0] fn_in;
  logic [NB-1:0] io_in = '0;
  logic [NB-1:0] io_out, io_oe, io_cs, io_sl, io_ie, io_pu, io_pd;

  logic [NB-1:0] all_ones = '1;
  logic [15:0]   sb_q [$];
  int            vec = 0;
  int            mis = 0;

  io_pad_ctrl #(.NUM_BIDIR(NB), .NUM_FUNC(NF), .SETTLE_CYCLES(SC)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .fn_out(fn_out), .fn_oe(fn_oe), .fn_in(fn_in), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .io_cs(io_cs), .io_sl(io_sl),
    .io_ie(io_ie), .io_pu(io_pu), .io_pd(io_pd)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus request; returns #1 after the accepting edge, or gives up after 40 cycles.
  task automatic cfg_access(input bit we, input logic [5:0] a, input logic [15:0] d,
                            output bit acc);
    acc = 1'b0;
    @(negedge clk_i);
    cfg_valid = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    for (int k = 0; k < 40; k++) begin
      if (cfg_ready) begin acc = 1'b1; break; end
      @(negedge clk_i);
    end
    if (acc) begin @(posedge clk_i); #1; end
    cfg_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
    bit acc;
    cfg_access(1'b1, a, d, acc);
  endtask

  // Returns X data if the request or the response never arrives.
  task automatic cfg_read(input logic [5:0] a, output logic [15:0] rd);
    bit acc;
    rd = 'x;
    cfg_access(1'b0, a, 16'h0, acc);
    if (acc) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk_i);
        if (cfg_rvalid) begin rd = cfg_rdata; break; end
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_i); #1;
      n++;
      if (cfg_ready) break;
    end
  endtask

  task automatic test_reset;
    logic [15:0] rd, e;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    vec++; if (cfg_ready !== 1'b0) begin mis++; $display("FAIL rst_ready: got %b want 0", cfg_ready); end
    vec++; if ({cfg_rvalid, cfg_rdata} !== 17'h0) begin mis++; $display("FAIL rst_rdata: got %b/%h want 0/0000", cfg_rvalid, cfg_rdata); end
    vec++; if ({io_oe, io_out, io_cs, io_sl, io_pu, io_pd} !== '0) begin mis++; $display("FAIL rst_pads: oe=%h out=%h want 0", io_oe, io_out); end
    vec++; if (io_ie !== all_ones) begin mis++; $display("FAIL rst_ie: got %h want %h", io_ie, all_ones); end
    rst_n = 1'b1;
    wait_ready(n);
    vec++; if (n !== SC) begin mis++; $display("FAIL hold_len: got %0d want %0d", n, SC); end
    sb_q.push_back(16'h0001);
    cfg_read(6'd63, rd);
    e = sb_q.pop_front();
    vec++; if (rd !== e) begin mis++; $display("FAIL status: got %h want %h", rd, e); end
  endtask

  task automatic test_gpio_commit;
    logic [15:0] rd, e;
    cfg_write(6'd5, 16'h0180);
    vec++; if (io_oe[5] !== 1'b0) begin mis++; $display("FAIL precommit_oe: got %b want 0", io_oe[5]); end
    sb_q.push_back(16'h0180);
    cfg_read(6'd5, rd);
    e = sb_q.pop_front();
    vec++; if (rd !== e) begin mis++; $display("FAIL pad5_rb: got %h want %h", rd, e); end
    vec++; if (cfg_rvalid !== 1'b0) begin
      @(negedge clk_i);
      if (cfg_rvalid !== 1'b0) begin mis++; $display("FAIL rvalid_pulse: got %b want 0", cfg_rvalid); end
    end
    cfg_write(6'd62, 16'h0001);
    vec++; if ({cfg_ready, io_oe[5], io_out[5]} !== 3'b000) begin mis++; $display("FAIL commit_cycle: ready/oe/out=%b want 000", {cfg_ready, io_oe[5], io_out[5]}); end
    @(posedge clk_i); #1;
    vec++; if ({io_oe[5], io_out[5], io_ie[5]} !== 3'b110) begin mis++; $display("FAIL post_commit: oe/out/ie=%b want 110", {io_oe[5], io_out[5], io_ie[5]}); end
  endtask

  task automatic test_func_mux;
    logic [3:0] pat;
    cfg_write(6'd7, 16'h0042);
    cfg_write(6'd62, 16'h0001);
    @(posedge clk_i); #1;
    pat = 4'b1001;
    for (int p = 0; p < 4; p++) begin
      fn_out[NB + 7]   = p[0];
      fn_oe[NB + 7]    = p[1];
      fn_out[7]        = ~p[0];
      fn_oe[7]         = ~p[1];
      fn_out[2*NB + 7] = ~p[0];
      fn_oe[2*NB + 7]  = ~p[1];
      #1;
      vec++; if ({io_out[7], io_oe[7]} !== {p[0], p[1]}) begin mis++; $display("FAIL fn2_mux[%0d]: out/oe=%b want %b", p, {io_out[7], io_oe[7]}, {p[0], p[1]}); end
    end
    vec++; if (io_ie[7] !== pat[0]) begin mis++; $display("FAIL fn2_ie: got %b want 1", io_ie[7]); end
  endtask

  task automatic test_pull_unmapped;
    logic [15:0] rd, e;
    logic [5:0]  ra [4];
    cfg_write(6'd3, 16'h0030);
    cfg_write(6'd2, 16'hFFFF);
    cfg_write(6'd60, 16'hFFFF);
    ra[0] = 6'd3; ra[1] = 6'd2; ra[2] = 6'd60; ra[3] = 6'd62;
    sb_q.push_back(16'h0010);
    sb_q.push_back(16'h01DF);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    for (int k = 0; k < 4; k++) begin
      cfg_read(ra[k], rd);
      e = sb_q.pop_front();
      vec++; if (rd !== e) begin mis++; $display("FAIL rb_addr%0d: got %h want %h", ra[k], rd, e); end
    end
  endtask

  task automatic test_sync;
    logic [15:0] rd, e;
    @(negedge clk_i);
    io_in[9] = 1'b1;
    #1;
    vec++; if (fn_in[9] !== 1'b1) begin mis++; $display("FAIL fn_in: got %b want 1", fn_in[9]); end
    sb_q.push_back(16'h0040);
    sb_q.push_back(16'h0240);
    for (int k = 0; k < 2; k++) begin
      cfg_read(6'd9, rd);
      e = sb_q.pop_front();
      vec++; if (rd !== e) begin mis++; $display("FAIL sync_rb%0d: got %h want %h", k, rd, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd, d, e;
    logic [5:0]  a;
    for (int k = 0; k < 6; k++) begin
      a = 6'($urandom_range(0, NB - 1));
      d = 16'($urandom);
      e = {6'b0, io_in[a], d[8:0]};
      if (d[4] && d[5]) e[5] = 1'b0;
      cfg_write(a, d);
      sb_q.push_back(e);
      cfg_read(a, rd);
      e = sb_q.pop_front();
      vec++; if (rd !== e) begin mis++; $display("FAIL b2b pad%0d wr %h: got %h want %h", a, d, rd, e); end
    end
  endtask

  task automatic test_reset_in_commit;
    logic [15:0] rd, e;
    logic [5:0]  ra [4];
    int n;
    cfg_write(6'd5, 16'h0180);
    cfg_write(6'd62, 16'h0001);
    @(posedge clk_i); #1;
    cfg_write(6'd3, 16'h0100);
    cfg_write(6'd62, 16'h0001);
    rst_n = 1'b0;
    #1;
    vec++; if ({io_oe, io_out, io_pu, io_pd} !== '0) begin mis++; $display("FAIL rst_commit_pads: oe=%h out=%h want 0", io_oe, io_out); end
    vec++; if ({cfg_ready, cfg_rvalid, io_ie} !== {2'b00, all_ones}) begin mis++; $display("FAIL rst_commit_ctl: ready=%b rvalid=%b ie=%h", cfg_ready, cfg_rvalid, io_ie); end
    @(negedge clk_i);
    rst_n = 1'b1;
    wait_ready(n);
    vec++; if (n !== SC) begin mis++; $display("FAIL hold_len2: got %0d want %0d", n, SC); end
    vec++; if ({io_oe[5], io_oe[7], io_ie[5]} !== 3'b001) begin mis++; $display("FAIL active_reset: oe5/oe7/ie5=%b want 001", {io_oe[5], io_oe[7], io_ie[5]}); end
    ra[0] = 6'd3; ra[1] = 6'd5; ra[2] = 6'd7; ra[3] = 6'd9;
    sb_q.push_back(16'h0040);
    sb_q.push_back(16'h0040);
    sb_q.push_back(16'h0040);
    sb_q.push_back(16'h0240);
    for (int k = 0; k < 4; k++) begin
      cfg_read(ra[k], rd);
      e = sb_q.pop_front();
      vec++; if (rd !== e) begin mis++; $display("FAIL post_rst_rb pad%0d: got %h want %h", ra[k], rd, e); end
    end
  endtask

  initial begin
    test_reset();
    test_gpio_commit();
    test_func_mux();
    test_pull_unmapped();
    test_sync();
    test_back_to_back();
    test_reset_in_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/io_pad_ctrl.md
# io_pad_ctrl

Pad configuration controller and pin-function arbiter sitting between the core logic and the 54 bidirectional GF180 pad cells. It holds a per-pad configuration register file (function select, drive strength, slew, input enable, pulls, GPIO value) written over a simple valid/ready register port. Staged updates are committed to all pads atomically. It holds every pad in a safe input-only state for a programmable settle period after reset, and muxes each pad between GPIO and up to three peripheral functions.

## Interface
- NUM_BIDIR, 54, number of bidirectional pads (max 62)
- NUM_FUNC, 4, functions per pad; function 0 is GPIO, 1..NUM_FUNC-1 are peripherals
- SETTLE_CYCLES, 1024, post-reset safe-hold duration in clk_i cycles (>=1)
- clk_i  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  register request valid
- cfg_ready  out  1  register request accepted when valid&ready
- cfg_we  in  1  1=write, 0=read
- cfg_addr  in  6  register address
- cfg_wdata  in  16  write data
- cfg_rdata  out  16  read data, qualified by cfg_rvalid
- cfg_rvalid  out  1  one-cycle pulse, read data valid
- fn_out  in  NUM_BIDIR*(NUM_FUNC-1)  peripheral output per function/pad, index f*NUM_BIDIR+i for function f+1
- fn_oe  in  NUM_BIDIR*(NUM_FUNC-1)  peripheral output enable, same indexing
- fn_in  out  NUM_BIDIR  unsynchronized pad input broadcast to peripherals (= io_in)
- io_in  in  NUM_BIDIR  pad Y
- io_out, io_oe, io_cs, io_sl, io_ie, io_pu, io_pd  out  NUM_BIDIR each  pad A/OE/CS/SL/IE/PU/PD

## Operation
- Per-pad config word (bits): [1:0] func, [2] cs, [3] sl, [4] pu, [5] pd, [6] ie, [7] gpio_oe, [8] gpio_out; [15:9] reserved, write-ignored, read 0.
- Reset value of every word, shadow and active: 0x0040 (ie=1, all else 0).
- Address map: 0..NUM_BIDIR-1 shadow config for pad i; 62 CTRL (write bit0=1 triggers commit, reads 0); 63 STATUS (read: bit0 settled, bit1 busy). Other addresses: writes ignored, reads return 0.
- Read of pad address returns the shadow word, with bit 9 = 2-flop-synchronized io_in[i].
- Write with pu=pd=1: stored pd forced to 0 (pull-up wins).
- func >= NUM_FUNC: stored as written; pad behaves as func 0.
- States: HOLD -> IDLE -> COMMIT -> IDLE.
  - HOLD (from reset): settle counter runs for SETTLE_CYCLES cycles; cfg_ready=0; pads forced to safe state (oe=0, out=0, cs=0, sl=0, pu=0, pd=0, ie=1). Then go to IDLE and set settled=1.
  - IDLE: cfg_ready=1. Write to CTRL bit0=1 goes to COMMIT.
  - COMMIT: one cycle, cfg_ready=0, busy=1; all shadow words are copied to active simultaneously; return to IDLE.
- Pad drive outside HOLD, from the active word:
  - func 0: io_out=gpio_out, io_oe=gpio_oe.
  - func f: io_out=fn_out, io_oe=fn_oe of function f.
  - cs/sl/ie/pu/pd come from the active word regardless of func.

## Timing
- Reset values: cfg_ready=0, cfg_rvalid=0, cfg_rdata=0, all pads in the safe state; settled=0, busy=0.
- HOLD lasts exactly SETTLE_CYCLES cycles after rst_n deasserts; cfg_ready rises on the following cycle.
- Read accepted in cycle N: cfg_rvalid=1 and cfg_rdata valid in N+1. cfg_rdata holds its value until the next read.
- Shadow write accepted in cycle N: readable at N+1; pads unaffected until a commit.
- CTRL commit accepted in N: COMMIT state in N+1 (cfg_ready=0); new pad outputs visible from N+2.
- Shadow writes never affect active registers mid-COMMIT, since no request is accepted that cycle.
- Peripheral path fn_out/fn_oe -> io_out/io_oe is combinational, zero latency.
- Asserting rst_n mid-operation returns immediately to HOLD with reset values, including discarding shadow contents.

## Structure
- Package io_pad_ctrl_pkg holds: field bit positions, CTRL/STATUS addresses, CFG_RESET (0x0040), and a state enum {HOLD, IDLE, COMMIT}.
- Sub-module io_pad_ctrl_sync: parameterized-width 2-flop synchronizer with async active-low reset to 0, used for io_in readback.

## Test plan
- Reset, SETTLE_CYCLES=16 -> cfg_ready low for 16 cycles, pads oe=0/ie=1; STATUS reads 0x1 afterward.
- Write pad 5 = 0x0180 (gpio_oe=1, out=1, ie=0) without commit -> io_oe[5]=0; readback 0x0180 (+bit9 per io_in); after CTRL=1, io_oe[5]=io_out[5]=1 two cycles after commit acceptance.
- Write pad 7 func=2 (0x0042), commit, toggle fn_out[1*54+7] and fn_oe -> io_out[7]/io_oe[7] follow in the same cycle.
- Write pad 3 = 0x0030 -> readback 0x0010 (pd cleared); unmapped address 60 -> read 0, write no effect.
- Drive io_in[9]=1 -> pad 9 readback bit9=1 no earlier than 2 cycles after the change.
- Assert rst_n during COMMIT -> all outputs return to the safe state, shadows read 0x0040 after the next HOLD.
